multiword_add_ctrl: RTL

- Sequencer that performs an (N*WORDS)-bit addition on one external N-bit ripple adder slice (Nbit-adder style: A, B, cin in; sum, cout out), one N-bit slice per clock, LSB slice first.
- Carry is held in a register between slices.
- Operand accept and result return each use a valid/ready handshake.
- Sits between a requesting unit and a shared narrow adder, so wide sums are produced without instantiating a wide adder.

---
 rtl/multiword_add_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: performs an (N*WORDS)-bit addition by stepping one
// external N-bit adder slice across the operands, LSB slice first.
// The carry between slices is held in a register. Operands come in and the
// result goes out over valid/ready handshakes.
module multiword_add_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               busy,
  output logic [N-1:0]       add_a,
  output logic [N-1:0]       add_b,
  output logic               add_cin,
  input  logic [N-1:0]       add_sum,
  input  logic               add_cout
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [N-1:0]   slice_a, slice_b;

  // Pick the operand slices addressed by the current slice index
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = a_q[i*N +: N];
        slice_b = b_q[i*N +: N];
      end
    end
  end

  // Handshake flags depend on state only, so no combinational path
  // exists between the requester and the consumer.
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);

  // The shared adder inputs stay at zero outside RUN so it does not toggle
  assign add_a   = (state_q == RUN) ? slice_a : '0;
  assign add_b   = (state_q == RUN) ? slice_b : '0;
  assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = add_cout;
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[i*N +: N] = add_sum;
          end
        end
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule
